// File: rtl/sd_result_collector_if.sv
// Digit-stream and result handshakes between the online multiplier, the
// signed-digit result collector and the downstream consumer.
interface sd_result_collector_if #(
  parameter int NDIGITS = 8,
  parameter int CW      = 4
);
  logic [1:0]       p_in;
  logic             in_vd;
  logic             in_rd;
  logic [NDIGITS:0] result;
  logic             result_vd;
  logic             result_rd;
  logic [CW-1:0]    digit_cnt;
  logic             err;

  modport master (
    output p_in, in_vd, result_rd,
    input  in_rd, result, result_vd, digit_cnt, err
  );

  modport slave (
    input  p_in, in_vd, result_rd,
    output in_rd, result, result_vd, digit_cnt, err
  );
endinterface

// File: rtl/sd_result_collector.sv
// On-the-fly Q/QM conversion of an MSD-first radix-2 signed-digit stream into
// a two's-complement word. Optional macro SDRC_ILLEGAL_DIGIT_EN flags 2'b11 digits.
module sd_result_collector #(
  parameter int NDIGITS = 8,
  parameter int CW      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sd_result_collector_if.slave  bus
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

  state_t           state_reg, state_next;
  logic [NDIGITS:0] q_reg, q_next;
  logic [NDIGITS:0] qm_reg, qm_next;
  logic [NDIGITS:0] result_reg, result_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             digit_plus, digit_minus;

  assign digit_plus  = (bus.p_in == 2'b10);
  assign digit_minus = (bus.p_in == 2'b01);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= COLLECT;
      q_reg      <= '0;
      qm_reg     <= '1;
      result_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      q_reg      <= q_next;
      qm_reg     <= qm_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    q_next      = q_reg;
    qm_next     = qm_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      COLLECT: begin
        if (bus.in_vd) begin
          // QM always tracks Q - 1 ulp, so a -1 digit needs no borrow chain
          if (digit_plus) begin
            q_next  = {q_reg[NDIGITS-1:0], 1'b1};
            qm_next = {q_reg[NDIGITS-1:0], 1'b0};
          end else if (digit_minus) begin
            q_next  = {qm_reg[NDIGITS-1:0], 1'b1};
            qm_next = {qm_reg[NDIGITS-1:0], 1'b0};
          end else begin
            q_next  = {q_reg[NDIGITS-1:0], 1'b0};
            qm_next = {qm_reg[NDIGITS-1:0], 1'b1};
          end
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            result_next = q_next;
            state_next  = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.result_rd) begin
          state_next = COLLECT;
          q_next     = '0;
          qm_next    = '1;
          cnt_next   = '0;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

`ifdef SDRC_ILLEGAL_DIGIT_EN
  logic err_reg;

  // Sticky until reset; survives result transfers on purpose
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (state_reg == COLLECT && bus.in_vd && bus.p_in == 2'b11) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_rd     = (state_reg == COLLECT);
  assign bus.result_vd = (state_reg == HOLD);
  assign bus.result    = result_reg;
  assign bus.digit_cnt = cnt_reg;

endmodule

// File: tb/tb_sd_result_collector.sv
// Randomized bench for sd_result_collector; the reference model sums digit
// weights directly and reduces the sum modulo 2^(N+1).
module tb_sd_result_collector;
  localparam int N  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sd_result_collector_if #(.NDIGITS(N), .CW(CW)) bus ();

  sd_result_collector #(.NDIGITS(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int model_cnt;
  int model_acc;
  logic exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int digit_val(input logic [1:0] c);
    case (c)
      2'b10:   return 1;
      2'b01:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [N:0] model_word();
    int tmp;
    tmp = model_acc;
    return tmp[N:0];
  endfunction

  task automatic push_digit(input logic [1:0] code);
    int waited = 0;
    bus.p_in  = code;
    bus.in_vd = 1'b1;
    while (bus.in_rd !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) begin
      check("in_rd_timeout", {31'b0, bus.in_rd}, 32'd1);
      bus.in_vd = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_vd = 1'b0;
    model_cnt++;
    model_acc += digit_val(code) * (1 << (N - model_cnt));
`ifdef SDRC_ILLEGAL_DIGIT_EN
    if (code == 2'b11) exp_err = 1'b1;
`endif
    check("digit_cnt", {28'b0, bus.digit_cnt}, model_cnt);
  endtask

  task automatic run_op(input logic [2*N-1:0] codes, input int gap, input int hold);
    logic [N:0] exp_res;
    model_cnt = 0;
    model_acc = 0;
    bus.result_rd = (hold == 0);
    for (int i = 0; i < N; i++) begin
      push_digit(codes[2*N-1-2*i -: 2]);
      if (i < N - 1 && gap > 0) begin
        repeat (gap) begin @(posedge clk); #1; end
        check("gap_cnt", {28'b0, bus.digit_cnt}, model_cnt);
      end
    end
    exp_res = model_word();
    check("vd_after_last", {31'b0, bus.result_vd}, 32'd1);
    check("rd_in_hold", {31'b0, bus.in_rd}, 32'd0);
    check("result", {27'b0, bus.result}, {27'b0, exp_res});
    for (int h = 1; h < hold; h++) begin
      bus.in_vd = 1'($urandom_range(0, 1));
      bus.p_in  = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      check("hold_vd", {31'b0, bus.result_vd}, 32'd1);
      check("hold_rd", {31'b0, bus.in_rd}, 32'd0);
      check("hold_result", {27'b0, bus.result}, {27'b0, exp_res});
    end
    bus.in_vd     = 1'b0;
    bus.result_rd = 1'b1;
    @(posedge clk); #1;
    bus.result_rd = 1'b0;
    check("post_vd", {31'b0, bus.result_vd}, 32'd0);
    check("post_rd", {31'b0, bus.in_rd}, 32'd1);
    check("post_cnt", {28'b0, bus.digit_cnt}, 32'd0);
    check("post_result", {27'b0, bus.result}, {27'b0, exp_res});
    check("err", {31'b0, bus.err}, {31'b0, exp_err});
    $display("op digits=%b gap=%0d hold=%0d result=%b expected=%b err=%b",
             codes, gap, hold, bus.result, exp_res, bus.err);
  endtask

  initial begin
    bus.p_in      = 2'b00;
    bus.in_vd     = 1'b0;
    bus.result_rd = 1'b0;
    exp_err       = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk); #1;
    check("rst_in_rd", {31'b0, bus.in_rd}, 32'd1);
    @(posedge clk); #1;
    check("rst_vd", {31'b0, bus.result_vd}, 32'd0);
    check("rst_result", {27'b0, bus.result}, 32'd0);
    check("rst_cnt", {28'b0, bus.digit_cnt}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("run_in_rd", {31'b0, bus.in_rd}, 32'd1);

    run_op(8'b10_00_01_10, 0, 0);   // 7/16
    run_op(8'b01_01_01_01, 0, 0);   // -15/16
    run_op(8'b00_00_00_00, 0, 0);
    run_op(8'b10_01_00_10, 3, 5);

    // Reset after two accepted digits discards the partial word
    model_cnt = 0;
    model_acc = 0;
    push_digit(2'b10);
    push_digit(2'b01);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    exp_err = 1'b0;
    check("midrst_cnt", {28'b0, bus.digit_cnt}, 32'd0);
    check("midrst_rd", {31'b0, bus.in_rd}, 32'd1);
    check("midrst_vd", {31'b0, bus.result_vd}, 32'd0);
    check("midrst_result", {27'b0, bus.result}, 32'd0);
    $display("reset after 2 digits cnt=%0d in_rd=%b", bus.digit_cnt, bus.in_rd);
    run_op(8'b01_10_10_00, 0, 0);

    run_op(8'b10_11_10_00, 0, 0);   // 10/16, illegal digit read as 0
    run_op(8'b00_10_00_01, 1, 2);   // err stays as it was

    for (int t = 0; t < 24; t++) begin
      run_op(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_result_collector.md
# sd_result_collector

Receiving end of the online multiplier's output handshake. Accepts the MSD-first stream of radix-2 signed digits (`p`, with `Out_vd`/`Out_rd`) and converts it on the fly into a two's-complement fixed-point word. The conversion is done with the Q/QM method, so no carry-propagate adder is used. It presents the finished word to downstream logic through a second valid/ready handshake, then re-arms for the next operation.

## Interface
- `NDIGITS`, default 8: digits per result; also the number of fraction bits.
- `CW`, default 4: width of the digit counter; must satisfy 2^CW > NDIGITS.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `p_in`  in  2  signed digit from the multiplier. Encoding is {plus, minus}: 2'b10 = +1, 2'b01 = −1, 2'b00 = 0, 2'b11 = 0 (illegal, see Configuration).
- `in_vd`  in  1  digit valid; connects to the multiplier's `Out_vd`.
- `in_rd`  out  1  digit ready; connects to the multiplier's `Out_rd`.
- `result`  out  NDIGITS+1  two's-complement value; sign bit plus NDIGITS fraction bits, weight 2^-NDIGITS per LSB.
- `result_vd`  out  1  result valid.
- `result_rd`  in  1  result ready from the consumer.
- `digit_cnt`  out  CW  number of digits accepted in the current operation.
- `err`  out  1  sticky illegal-digit flag.

## Operation
- Two states: COLLECT and HOLD. Reset state is COLLECT.
- `in_rd` = 1 exactly in COLLECT. `result_vd` = 1 exactly in HOLD. Both are decoded from the registered state only; there is no combinational path from inputs.
- A digit is accepted when `in_vd & in_rd` at a rising edge.
- Internal registers Q and QM, each NDIGITS+1 bits. At reset and on re-arm: Q = 0, QM = all ones.
- On each accept, with `p_in` decoded to q:
  - q = +1: Q ← {Q[NDIGITS-1:0],1}, QM ← {Q[NDIGITS-1:0],0}
  - q = 0: Q ← {Q[NDIGITS-1:0],0}, QM ← {QM[NDIGITS-1:0],1}
  - q = −1: Q ← {QM[NDIGITS-1:0],1}, QM ← {QM[NDIGITS-1:0],0}
- Arithmetic wraps modulo 2^(NDIGITS+1). The final value is exact for any digit string, since |value| < 1.
- Each accept increments `digit_cnt`. On the accept that makes the count equal NDIGITS: latch the updated Q into `result` and go to HOLD.
- In HOLD: no digits are accepted, and `in_vd` is ignored.
- `result_vd & result_rd` at an edge: go to COLLECT, clear Q, QM and `digit_cnt`. `result` holds its last value.
- Reset mid-operation, in either state: every register returns to its reset value at that edge. A partially collected word is discarded.
- Reset values: `in_rd` = 1, `result_vd` = 0, `result` = 0, `digit_cnt` = 0, `err` = 0.

## Timing
- `in_rd` is high in the first cycle after `rst_n` is sampled high. During the reset cycle it already reflects the COLLECT reset value.
- Throughput is one digit per cycle while `in_vd` is held high.
- Latency: `result_vd` and `result` are valid in the cycle after the NDIGITS-th accept.
- `result_rd` may be high before `result_vd`. The transfer then completes on the first HOLD cycle, so HOLD lasts a minimum of 1 cycle.
- After the result transfer edge, `in_rd` = 1 in the next cycle. There is no same-cycle bypass from HOLD to accepting a digit.
- `in_vd` may drop between digits, as the multiplier does after each handshake. Gaps do not affect Q, QM or `digit_cnt`.

## Configuration
- `SDRC_ILLEGAL_DIGIT_EN` defined:
  - An accepted `p_in` == 2'b11 sets `err`. It stays set until `rst_n` = 0.
  - That digit is still treated as 0.
- Not defined: `err` is tied to 0 and 2'b11 is silently treated as 0.

## Test plan
- NDIGITS = 4, back-to-back digits +1, 0, −1, +1, `result_rd` = 1 → `result` = 5'b00111 (7/16), `result_vd` high one cycle after the 4th accept, `in_rd` high again the following cycle.
- NDIGITS = 4, digits −1, −1, −1, −1 → `result` = 5'b10001 (−15/16). Digits 0, 0, 0, 0 → 5'b00000.
- Digits with 3-cycle `in_vd` gaps; `result_rd` held low 5 cycles → `result_vd` stays high for those 5 cycles, `in_rd` = 0 throughout, and extra `in_vd` pulses do not change `result`.
- Assert `rst_n` = 0 after 2 accepted digits → next cycle `digit_cnt` = 0, `in_rd` = 1. A following full 4-digit stream produces the correct value, unaffected by the discarded digits.
- With `SDRC_ILLEGAL_DIGIT_EN`: digit 2'b11 at position 2 of +1, 11, +1, 0 → `err` = 1 and stays 1 across later operations, `result` = 5'b01010 (10/16). Without the macro: same `result`, `err` = 0.
